vec_beat_streamer: RTL and testbench
====================================

// Module: vec_beat_streamer
// PURPOSE
//   Producer side of the accumulator beat interface (in_valid / partial_sum).
//   On start: reads BEATS words from two operand RAMs (A, B), each word 4 packed
//   unsigned int8 lanes. Emits one partial_sum = sum of 4 lane products per beat.
//   Sits between operand buffers and the accumulator; owns beat count and pacing.
//   Accumulator has no ready, so every issued beat is consumed.
// PARAMETERS
//   BEATS   250  beats per vector (1000 elems / 4 lanes); 1..256
//   ADDR_W  8    operand RAM address width
//   LANES   4    int8 lanes per word (fixed 4; data width 8*LANES)
//   W_OUT   18   partial_sum width; 4*255*255=260100 < 2^18, no overflow
// PORTS
//   clk          in   1       rising-edge clock
//   rst          in   1       synchronous, active-high reset
//   start        in   1       1-cycle pulse; accepted only in IDLE
//   base_addr    in   ADDR_W  first read address; latched on accepted start
//   hold         in   1       stall read issue while high; in-flight beats drain
//   mem_rd_en    out  1       read strobe to both RAMs (registered)
//   mem_rd_addr  out  ADDR_W  read address (registered)
//   mem_rd_a     in   32      RAM A data; valid 1 cycle after mem_rd_en
//   mem_rd_b     in   32      RAM B data; valid 1 cycle after mem_rd_en
//   out_valid    out  1       beat strobe to accumulator in_valid
//   partial_sum  out  W_OUT   beat value to accumulator partial_sum
//   busy         out  1       high from accepted start until done cycle, inclusive
//   done         out  1       1-cycle pulse with last out_valid beat
// BEHAVIOUR
//   Reset: all outputs 0; state IDLE; issue count 0; pipeline valid bits cleared.
//   FSM: IDLE -start-> ISSUE -last read issued-> DRAIN -last beat out-> IDLE.
//   - IDLE: start=1 latches base_addr; next state ISSUE; busy=1 next cycle.
//   - ISSUE: each cycle with hold=0 asserts mem_rd_en, addr = base+k (k=0..BEATS-1).
//     hold=1: mem_rd_en=0, addr holds; no beat lost or duplicated.
//   - DRAIN: no reads; wait for in-flight beats (max 2); exit on last out_valid.
//   Pipeline (fixed): rd_en at cycle t -> RAM data at t+1 -> out_valid/partial_sum
//     registered at t+2. start at edge 0 -> first rd_en cycle 1 -> first beat cycle 3.
//   Arithmetic: partial_sum = sum over i<4 of a[8i+7:8i]*b[8i+7:8i]; unsigned,
//     zero-extended to W_OUT; lane 0 = bits [7:0].
//   Address wraps mod 2^ADDR_W (base+k overflow wraps, no error).
//   Exactly BEATS out_valid pulses per start; done coincides with the BEATS-th.
//   partial_sum holds last value when out_valid=0.
//   start while busy (incl. done cycle): ignored.
//   start in the cycle after done: accepted (back-to-back vectors).
//   BEATS=1: one read, one beat, done with that beat.
//   hold during DRAIN has no effect.
//   rst mid-operation: abort immediately. No further rd_en/out_valid/done;
//     accumulator must be reset in the same cycle.
// TESTING
//   1. BEATS=4, base=0x10, A=B=0x01010101 all words, hold=0 -> rd_en cycles 1-4
//      (addr 0x10..0x13); out_valid cycles 3-6, partial_sum=4; done cycle 6; busy 1..6.
//   2. Max value: all A/B=0xFFFFFFFF, BEATS=250 -> every partial_sum=260100,
//      250 beats; downstream accumulator final_sum=65025000.
//   3. hold pattern 1010... during ISSUE -> rd_en only in hold=0 cycles; still exactly
//      BEATS beats, addresses strictly sequential, done after last beat.
//   4. base=0xFE, BEATS=4 -> addresses 0xFE,0xFF,0x00,0x01.
//   5. start pulsed at cycles 2 and 5 while busy -> ignored; start on the cycle
//      after done -> second run, first beat 3 cycles later.
//   6. rst asserted after 2 beats -> next cycle all outputs 0, IDLE; no more beats;
//      new start runs a full clean BEATS-beat vector.

Source files
------------

// File: rtl/vec_beat_streamer.sv
// Operand streamer: reads BEATS packed int8 word pairs from RAMs A/B and emits
// one lane-wise dot product per beat to the accumulator, with issue stall on hold.
//
// state | meaning
// IDLE  | waiting for start; busy drops the cycle after done
// ISSUE | one read per non-hold cycle until BEATS reads are issued
// DRAIN | reads finished, waiting for the in-flight beats to come out
module vec_beat_streamer #(
  parameter int BEATS  = 250,
  parameter int ADDR_W = 8,
  parameter int LANES  = 4,
  parameter int W_OUT  = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic                 hold,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_rd_addr,
  input  logic [8*LANES-1:0]   mem_rd_a,
  input  logic [8*LANES-1:0]   mem_rd_b,
  output logic                 out_valid,
  output logic [W_OUT-1:0]     partial_sum,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(BEATS + 1);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t            state;
  logic [CW-1:0]     rd_cnt;
  logic [CW-1:0]     beat_cnt;
  logic [ADDR_W-1:0] next_addr;
  logic              data_vld;
  logic [W_OUT-1:0]  sum_next;
  logic [15:0]       prod;

  always_comb begin
    sum_next = '0;
    prod     = '0;
    for (int i = 0; i < LANES; i++) begin
      prod     = 16'(mem_rd_a[8*i +: 8]) * 16'(mem_rd_b[8*i +: 8]);
      sum_next = sum_next + W_OUT'(prod);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rd_cnt      <= '0;
      beat_cnt    <= '0;
      next_addr   <= '0;
      data_vld    <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      out_valid   <= 1'b0;
      partial_sum <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      mem_rd_en <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      data_vld  <= mem_rd_en;

      case (state)
        IDLE: begin
          busy <= 1'b0;
          // done is still high in the done cycle, so a start there is ignored
          if (start && !done) begin
            busy      <= 1'b1;
            state     <= ISSUE;
            rd_cnt    <= '0;
            beat_cnt  <= '0;
            next_addr <= base_addr;
            if (!hold) begin
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= base_addr;
              next_addr   <= base_addr + ADDR_W'(1);
              rd_cnt      <= CW'(1);
              if (BEATS == 1) state <= DRAIN;
            end
          end
        end
        ISSUE: begin
          if (!hold) begin
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= next_addr;
            next_addr   <= next_addr + ADDR_W'(1);
            rd_cnt      <= rd_cnt + CW'(1);
            if (rd_cnt == LAST) state <= DRAIN;
          end
        end
        DRAIN: ;
        default: state <= IDLE;
      endcase

      if (data_vld) begin
        out_valid   <= 1'b1;
        partial_sum <= sum_next;
        beat_cnt    <= beat_cnt + CW'(1);
        if (beat_cnt == LAST) begin
          done  <= 1'b1;
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_vec_beat_streamer.sv
// Directed bench: a 4-beat streamer for timing/hold/wrap/restart/reset cases and
// a 250-beat streamer for the full-scale max-value vector.
module tb_vec_beat_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, hold;
  logic [7:0]  base;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [31:0] rd_a, rd_b;
  logic        ov;
  logic [17:0] ps;
  logic        busy, done;

  logic        start_l, hold_l;
  logic [7:0]  base_l;
  logic        rd_en_l;
  logic [7:0]  rd_addr_l;
  logic [31:0] rd_a_l, rd_b_l;
  logic        ov_l;
  logic [17:0] ps_l;
  logic        busy_l, done_l;

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];

  vec_beat_streamer #(.BEATS(4), .ADDR_W(8), .LANES(4), .W_OUT(18)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base), .hold(hold),
    .mem_rd_en(rd_en), .mem_rd_addr(rd_addr), .mem_rd_a(rd_a), .mem_rd_b(rd_b),
    .out_valid(ov), .partial_sum(ps), .busy(busy), .done(done));

  vec_beat_streamer #(.BEATS(250), .ADDR_W(8), .LANES(4), .W_OUT(18)) dut_l (
    .clk(clk), .rst(rst), .start(start_l), .base_addr(base_l), .hold(hold_l),
    .mem_rd_en(rd_en_l), .mem_rd_addr(rd_addr_l), .mem_rd_a(rd_a_l), .mem_rd_b(rd_b_l),
    .out_valid(ov_l), .partial_sum(ps_l), .busy(busy_l), .done(done_l));

  // operand RAMs: data appears the cycle after the read strobe
  always @(posedge clk) begin
    if (rd_en) begin
      rd_a <= mem_a[rd_addr];
      rd_b <= mem_b[rd_addr];
    end
    if (rd_en_l) begin
      rd_a_l <= mem_a[rd_addr_l];
      rd_b_l <= mem_b[rd_addr_l];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0]        base;
    logic [3:0][31:0]  a;
    logic [3:0][31:0]  b;
    logic [7:0]        hold_pat;
    logic [3:0][17:0]  exp;
  } vec_t;

  vec_t tbl [4];

  task automatic set_vec(input int idx, input logic [7:0] bs, input logic [127:0] a,
                         input logic [127:0] b, input logic [7:0] hp, input logic [71:0] e);
    tbl[idx].base     = bs;
    tbl[idx].a        = a;
    tbl[idx].b        = b;
    tbl[idx].hold_pat = hp;
    tbl[idx].exp      = e;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [7:0] ad;
    int nrd, nbeat, first_rd, first_ov, done_c, busy_c;
    logic prev_hold;
    nrd = 0; nbeat = 0; first_rd = 0; first_ov = 0; done_c = 0; busy_c = 0;
    for (int k = 0; k < 4; k++) begin
      ad = v.base + 8'(k);
      mem_a[ad] = v.a[k];
      mem_b[ad] = v.b[k];
    end
    base  = v.base;
    start = 1'b1;
    hold  = v.hold_pat[0];
    prev_hold = hold;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (rd_en) begin
        chk({tag, " rd_addr"}, rd_addr, 8'(v.base + 8'(nrd)));
        chk({tag, " rd_en_under_hold"}, prev_hold, 0);
        if (nrd == 0) first_rd = c;
        nrd++;
      end
      if (ov) begin
        if (nbeat < 4) chk({tag, " partial_sum"}, ps, v.exp[nbeat]);
        if (nbeat == 0) first_ov = c;
        nbeat++;
        if (done) begin
          done_c = c;
          chk({tag, " done_beat_no"}, nbeat, 4);
        end
      end else if (done) begin
        chk({tag, " done_without_beat"}, 1, 0);
      end
      if (busy) busy_c++;
      hold = (c < 8) ? v.hold_pat[c] : 1'b0;
      prev_hold = hold;
      if (done_c != 0 && c >= done_c + 2) break;
    end
    hold = 1'b0;
    chk({tag, " reads"}, nrd, 4);
    chk({tag, " beats"}, nbeat, 4);
    chk({tag, " done_seen"}, done_c != 0, 1);
    chk({tag, " busy_cycles"}, busy_c, done_c);
    if (v.hold_pat == 8'h00) begin
      chk({tag, " first_rd_cycle"}, first_rd, 1);
      chk({tag, " first_beat_cycle"}, first_ov, 3);
      chk({tag, " done_cycle"}, done_c, 6);
    end
  endtask

  initial begin
    logic e_ov, e_rd, e_done;
    logic [17:0] e_ps;
    logic [7:0] e_addr;
    int n_l, bad_l, done_l_beat;
    longint acc;

    rst = 1'b1; start = 1'b0; hold = 1'b0; base = '0;
    start_l = 1'b0; hold_l = 1'b0; base_l = '0;

    set_vec(0, 8'h10, {4{32'h01010101}}, {4{32'h01010101}}, 8'h00, {4{18'd4}});
    set_vec(1, 8'h20, {32'h00000000, 32'h10101010, 32'h000000FF, 32'h04030201},
                      {32'hFFFFFFFF, 32'h02020202, 32'h000000FF, 32'h01010101},
                      8'b0101_0101, {18'd0, 18'd128, 18'd65025, 18'd10});
    set_vec(2, 8'hFE, {32'h0A000000, 32'h00FF00FF, 32'hFFFFFFFF, 32'h01020304},
                      {32'h0B000000, 32'hFF00FF00, 32'hFFFFFFFF, 32'h04030201},
                      8'h00, {18'd110, 18'd0, 18'd260100, 18'd20});
    set_vec(3, 8'h40, {32'h03000000, 32'h00010000, 32'h00000100, 32'h00000007},
                      {32'h07000000, 32'h00050000, 32'h00000100, 32'h00000006},
                      8'b1100_1100, {18'd21, 18'd5, 18'd1, 18'd42});

    repeat (3) @(negedge clk);
    chk("rst rd_en", rd_en, 0);
    chk("rst out_valid", ov, 0);
    chk("rst partial_sum", ps, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst large busy", busy_l, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
      repeat (2) @(negedge clk);
    end

    // starts while busy and in the done cycle are dropped; the next cycle restarts
    for (int k = 0; k < 4; k++) begin
      mem_a[8'h30 + 8'(k)] = 32'h02020202; mem_b[8'h30 + 8'(k)] = 32'h01010101;
      mem_a[8'h50 + 8'(k)] = 32'h03030303; mem_b[8'h50 + 8'(k)] = 32'h01010101;
    end
    base = 8'h30; start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      e_rd   = (c >= 1 && c <= 4) || (c >= 8 && c <= 11);
      e_addr = (c <= 4) ? 8'(8'h30 + 8'(c - 1)) : 8'(8'h50 + 8'(c - 8));
      e_ov   = (c >= 3 && c <= 6) || (c >= 10 && c <= 13);
      e_ps   = (c <= 6) ? 18'd8 : 18'd12;
      e_done = (c == 6) || (c == 13);
      chk($sformatf("restart rd_en c%0d", c), rd_en, e_rd);
      if (e_rd) chk($sformatf("restart rd_addr c%0d", c), rd_addr, e_addr);
      chk($sformatf("restart out_valid c%0d", c), ov, e_ov);
      if (e_ov) chk($sformatf("restart partial_sum c%0d", c), ps, e_ps);
      chk($sformatf("restart done c%0d", c), done, e_done);
      start = (c == 2) || (c == 5) || (c == 6) || (c == 7);
      base  = (c == 7) ? 8'h50 : 8'h77;
    end
    start = 1'b0;
    repeat (2) @(negedge clk);

    // reset after two beats aborts everything
    base = 8'h10; start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("abort pre beat", ov, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort rd_en", rd_en, 0);
    chk("abort out_valid", ov, 0);
    chk("abort partial_sum", ps, 0);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    n_l = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ov || rd_en || done || busy) n_l++;
    end
    chk("abort quiet cycles", n_l, 0);
    run_vec(tbl[0], "post_abort");
    repeat (2) @(negedge clk);

    // full-scale vector on the 250-beat instance
    for (int k = 0; k < 256; k++) begin
      mem_a[k] = 32'hFFFFFFFF;
      mem_b[k] = 32'hFFFFFFFF;
    end
    n_l = 0; bad_l = 0; done_l_beat = 0; acc = 0;
    base_l = 8'h00; start_l = 1'b1;
    for (int c = 1; c <= 700; c++) begin
      @(negedge clk);
      start_l = 1'b0;
      if (ov_l) begin
        n_l++;
        acc += ps_l;
        if (ps_l !== 18'd260100) bad_l++;
      end
      if (done_l) done_l_beat = ov_l ? n_l : -1;
      if (done_l_beat != 0 && !busy_l) break;
    end
    chk("max beats", n_l, 250);
    chk("max bad sums", bad_l, 0);
    chk("max final_sum", acc, 65025000);
    chk("max done beat", done_l_beat, 250);
    chk("max busy after", busy_l, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
